// File: rtl/adc_request_arbiter.sv
// rtl/adc_request_arbiter.sv - round-robin arbiter sharing one ADC sequencer among NUM_REQ requesters
module adc_request_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_ch,
    output logic                   adc_go,
    input  logic                   adc_done,
    input  logic [95:0]            adc_outs,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [11:0]            rsp_data,
    output logic [2:0]             rsp_ch,
    output logic                   rsp_timeout,
    output logic [15:0]            conv_count
);

    typedef enum logic [1:0] {S_IDLE, S_GO, S_RELEASE} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [2:0]         ptr, ptr_n;
    logic [2:0]         ch_lat, ch_lat_n;
    logic [15:0]        tcnt, tcnt_n;

    logic               go_n;
    logic [2:0]         grant_n;
    logic [NUM_REQ-1:0] rsp_valid_n;
    logic [11:0]        rsp_data_n;
    logic [2:0]         rsp_ch_n;
    logic               rsp_to_n;
    logic [15:0]        count_n;

    logic [7:0]         req_ext;
    logic [3:0]         sum;
    logic               any_req;
    logic [2:0]         winner;
    logic [2:0]         win_ch;
    logic [11:0]        sel_data;
    logic               timed_out;

    // Search upward from pointer+1, wrapping at NUM_REQ; first set request wins.
    always_comb begin
        req_ext = 8'(req);
        sum     = '0;
        any_req = 1'b0;
        winner  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(NUM_REQ)) begin
                sum = sum - 4'(NUM_REQ);
            end
            if (!any_req && req_ext[sum[2:0]]) begin
                any_req = 1'b1;
                winner  = sum[2:0];
            end
        end
    end

    always_comb begin
        win_ch = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) begin
                win_ch = req_ch[3*i +: 3];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (ch_lat == 3'(k)) begin
                sel_data = adc_outs[12*k +: 12];
            end
        end
    end

    assign timed_out = (tcnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_RELEASE;
            ptr         <= 3'(NUM_REQ - 1);
            ch_lat      <= '0;
            tcnt        <= '0;
            adc_go      <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_ch      <= '0;
            rsp_timeout <= 1'b0;
            conv_count  <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            ch_lat      <= ch_lat_n;
            tcnt        <= tcnt_n;
            adc_go      <= go_n;
            busy        <= (state_n != S_IDLE);
            grant_id    <= grant_n;
            rsp_valid   <= rsp_valid_n;
            rsp_data    <= rsp_data_n;
            rsp_ch      <= rsp_ch_n;
            rsp_timeout <= rsp_to_n;
            conv_count  <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (any_req) state_n = S_GO;
            S_GO:      if (adc_done || timed_out) state_n = S_RELEASE;
            S_RELEASE: if (!adc_done) state_n = S_IDLE;
            default:   state_n = S_RELEASE;
        endcase
    end

    // Next values of the registered outputs; done takes priority over timeout.
    always_comb begin
        go_n        = adc_go;
        grant_n     = grant_id;
        ptr_n       = ptr;
        ch_lat_n    = ch_lat;
        tcnt_n      = tcnt;
        rsp_valid_n = '0;
        rsp_data_n  = rsp_data;
        rsp_ch_n    = rsp_ch;
        rsp_to_n    = rsp_timeout;
        count_n     = conv_count;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    go_n     = 1'b1;
                    grant_n  = winner;
                    ptr_n    = winner;
                    ch_lat_n = win_ch;
                    tcnt_n   = '0;
                end
            end
            S_GO: begin
                tcnt_n = tcnt + 16'd1;
                if (adc_done) begin
                    go_n        = 1'b0;
                    rsp_valid_n = ONE_HOT0 << grant_id;
                    rsp_data_n  = sel_data;
                    rsp_ch_n    = ch_lat;
                    rsp_to_n    = 1'b0;
                    count_n     = conv_count + 16'd1;
                end else if (timed_out) begin
                    go_n        = 1'b0;
                    rsp_valid_n = ONE_HOT0 << grant_id;
                    rsp_data_n  = '0;
                    rsp_ch_n    = ch_lat;
                    rsp_to_n    = 1'b1;
                end
            end
            default: begin
                go_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_request_arbiter.sv
// tb/tb_adc_request_arbiter.sv - scoreboard bench for adc_request_arbiter
module tb_adc_request_arbiter;

    localparam int NUM_REQ = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic [3*NUM_REQ-1:0] req_ch;
    logic               adc_go;
    logic               adc_done = 1'b0;
    logic [95:0]        adc_outs;
    logic               busy;
    logic [2:0]         grant_id;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [11:0]        rsp_data;
    logic [2:0]         rsp_ch;
    logic               rsp_timeout;
    logic [15:0]        conv_count;

    adc_request_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(16'd24)) dut (
        .clock(clock), .reset(reset), .req(req), .req_ch(req_ch),
        .adc_go(adc_go), .adc_done(adc_done), .adc_outs(adc_outs),
        .busy(busy), .grant_id(grant_id), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_ch(rsp_ch), .rsp_timeout(rsp_timeout),
        .conv_count(conv_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NUM_REQ-1:0] vld;
        logic [11:0]        data;
        logic [2:0]         ch;
        logic               to;
        logic [15:0]        cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    int   n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
                check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                check("rsp_ch", 32'(rsp_ch), 32'(mon_e.ch));
                check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
                check("conv_count", 32'(conv_count), 32'(mon_e.cnt));
                check("adc_go_at_rsp", 32'(adc_go), 32'd0);
            end
        end
    end

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        adc_done = 1'b0;
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_go(input string tag);
        int w;
        w = 0;
        while (!adc_go && w < 60) begin
            @(negedge clock);
            w++;
        end
        if (!adc_go) begin
            total++;
            bad++;
            $display("FAIL %s: adc_go never rose within 60 cycles", tag);
        end
    endtask

    task automatic go_delay(output int d);
        d = 0;
        do begin
            @(negedge clock);
            d++;
        end while (!adc_go && d < 20);
    endtask

    // Grant, hold done after dly cycles of go, keep done hold cycles after the response.
    task automatic serve(input int id, input logic [2:0] ch, input logic [11:0] data,
                         input int dly, input int hold, input logic [NUM_REQ-1:0] req_after);
        exp_t e;
        wait_go("wait_go");
        check("grant_id", 32'(grant_id), 32'(id));
        check("busy_in_go", 32'(busy), 32'd1);
        exp_cnt++;
        e.vld  = 4'b0001 << id;
        e.data = data;
        e.ch   = ch;
        e.to   = 1'b0;
        e.cnt  = 16'(exp_cnt);
        exp_q.push_back(e);
        repeat (dly) @(negedge clock);
        adc_done = 1'b1;
        @(negedge clock);
        req = req_after;
        repeat (hold) begin
            @(negedge clock);
            check("go_low_while_done", 32'(adc_go), 32'd0);
        end
        adc_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [11:0] vals [8];
        vals = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'hABC, 12'h777, 12'h888};
        for (int k = 0; k < 8; k++) adc_outs[12*k +: 12] = vals[k];
        req_ch = {3'd0, 3'd7, 3'd2, 3'd5};

        // Reset values, then single requester
        do_reset();
        check("rst_adc_go", 32'(adc_go), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_ch", 32'(rsp_ch), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_conv_count", 32'(conv_count), 32'd0);
        req = 4'b0001;
        serve(0, 3'd5, 12'hABC, 20, 0, 4'b0000);

        // Fairness with all four requesting
        do_reset();
        req = 4'b1111;
        serve(0, 3'd5, 12'hABC, 3, 0, 4'b1111);
        serve(1, 3'd2, 12'h333, 3, 0, 4'b1111);
        serve(2, 3'd7, 12'h888, 3, 0, 4'b1111);
        serve(3, 3'd0, 12'h111, 3, 0, 4'b1111);
        serve(0, 3'd5, 12'hABC, 3, 0, 4'b1111);
        serve(1, 3'd2, 12'h333, 3, 0, 4'b0000);

        // Done held 10 cycles after go drops; pending requester 1 waits
        req = 4'b0001;
        serve(0, 3'd5, 12'hABC, 4, 10, 4'b0010);
        go_delay(n);
        check("go_after_done_low", 32'(n), 32'd2);
        serve(1, 3'd2, 12'h333, 2, 0, 4'b0000);

        // Timeout: go high exactly TIMEOUT_CYC cycles, zero data, count unchanged
        do_reset();
        req = 4'b0001;
        wait_go("wait_go_timeout");
        e.vld = 4'b0001; e.data = 12'h000; e.ch = 3'd5; e.to = 1'b1; e.cnt = 16'd0;
        exp_q.push_back(e);
        n = 1;
        while (n < 60) begin
            @(negedge clock);
            if (!adc_go) break;
            n++;
        end
        check("timeout_go_cycles", 32'(n), 32'd24);
        req = 4'b0000;

        // Reset mid-conversion with a stale done
        @(negedge clock);
        req = 4'b0001;
        wait_go("wait_go_midreset");
        repeat (5) @(negedge clock);
        reset = 1'b1;
        adc_done = 1'b1;
        req = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0;
        check("go_after_reset", 32'(adc_go), 32'd0);
        check("count_after_reset", 32'(conv_count), 32'd0);
        req = 4'b0001;
        repeat (3) begin
            @(negedge clock);
            check("go_low_stale_done", 32'(adc_go), 32'd0);
        end
        adc_done = 1'b0;
        go_delay(n);
        check("go_after_stale_done", 32'(n), 32'd2);
        serve(0, 3'd5, 12'hABC, 3, 0, 4'b0000);

        // Done on the final count cycle wins over timeout
        do_reset();
        req = 4'b0001;
        serve(0, 3'd5, 12'hABC, 23, 0, 4'b0000);

        repeat (5) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
